// File: rtl/vu_peak_bcd.sv
// vu_peak_bcd: tracks the peak magnitude of a signed audio stream with hold
// and decay, then converts the held peak to five BCD digits at a fixed
// refresh rate using a sequential shift-add-3 engine.
module vu_peak_bcd #(
  parameter int unsigned HOLD_SAMPLES   = 4800,
  parameter int unsigned DECAY_SHIFT    = 4,
  parameter int unsigned REFRESH_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  output logic [14:0] peak,
  output logic [3:0]  digit4,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        digits_valid,
  output logic        busy
);

  localparam int unsigned HW = $clog2(HOLD_SAMPLES + 1);
  localparam int unsigned RW = $clog2(REFRESH_CYCLES);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SAMPLES);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [HW-1:0] hold;
  logic [RW-1:0] refresh;
  logic          tick;
  logic          tick_q;
  logic [14:0]   mag;
  logic [15:0]   neg;
  logic [14:0]   decay;
  state_t        state;
  logic [3:0]    iter;
  logic [19:0]   bcd;
  logic [19:0]   adj;
  logic [14:0]   bin;

  assign tick = (refresh == REF_LAST);

  // Saturating absolute value of the incoming sample.
  always_comb begin
    neg = ~sample + 16'd1;
    if (sample == 16'h8000)
      mag = 15'h7fff;
    else if (sample[15])
      mag = neg[14:0];
    else
      mag = sample[14:0];
  end

  // Decay step, never smaller than one so the peak always reaches zero.
  always_comb begin
    decay = peak >> DECAY_SHIFT;
    if (decay == '0)
      decay = 15'd1;
  end

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Peak tracker: capture louder samples, hold, then decay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak <= '0;
      hold <= '0;
    end else if (clear) begin
      peak <= '0;
      hold <= '0;
    end else if (sample_valid) begin
      if (mag >= peak) begin
        peak <= mag;
        hold <= HOLD_INIT;
      end else if (hold != '0) begin
        hold <= hold - 1'b1;
      end else if (peak != '0) begin
        peak <= peak - decay;
      end
    end
  end

  // Free-running refresh divider; tick is registered so the conversion
  // captures the peak value written on the tick edge itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q  <= tick;
      refresh <= tick ? '0 : refresh + 1'b1;
    end
  end

  // Conversion FSM: capture, 15 shift-add-3 steps, publish digits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      iter         <= '0;
      bcd          <= '0;
      bin          <= '0;
      busy         <= 1'b0;
      digits_valid <= 1'b0;
      digit4       <= '0;
      digit3       <= '0;
      digit2       <= '0;
      digit1       <= '0;
      digit0       <= '0;
    end else begin
      digits_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_q) begin
            bin   <= peak;
            bcd   <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          iter       <= iter + 4'd1;
          if (iter == 4'd14)
            state <= DONE;
        end
        DONE: begin
          digit4       <= bcd[19:16];
          digit3       <= bcd[15:12];
          digit2       <= bcd[11:8];
          digit1       <= bcd[7:4];
          digit0       <= bcd[3:0];
          digits_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vu_peak_bcd.md
Name: vu_peak_bcd

Overview:
Upstream feeder for the per-digit 7-segment hex decoders in the VU meter.
- Takes a stream of signed audio samples and tracks peak magnitude with hold and exponential-style decay.
- At a fixed display refresh rate, converts the held peak to five BCD nibbles with a sequential shift-add-3 (double dabble) engine.
- Each nibble drives one hex decoder instance directly.

Parameters:
- HOLD_SAMPLES, 4800: samples a new peak is held before decay starts (>=1).
- DECAY_SHIFT, 4: decay step per sample after hold expires is peak>>DECAY_SHIFT (1..14).
- REFRESH_CYCLES, 5000000: clocks between display refresh ticks (10 Hz at 50 MHz); must be >=32.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous; zeroes peak and hold counter.
- sample_valid  in  1  one-cycle qualifier for sample.
- sample  in  16  signed two's-complement audio sample.
- peak  out  15  current tracked peak magnitude (registered).
- digit4..digit0  out  4 each  BCD digits of last converted peak; digit4 is ten-thousands, digit0 is units.
- digits_valid  out  1  one-cycle pulse when digit outputs update.
- busy  out  1  high while conversion FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): peak=0, hold counter=0, refresh counter=0, FSM=IDLE, all digits=0, digits_valid=0, busy=0.
- Magnitude: mag = |sample|, saturated; -32768 yields 32767. Result is 15-bit unsigned.
- Peak update, on a cycle with sample_valid=1 and clear=0:
  - mag >= peak: peak<=mag, hold<=HOLD_SAMPLES.
  - Else if hold>0: hold<=hold-1, peak unchanged.
  - Else if peak>0: peak<=peak-max(peak>>DECAY_SHIFT, 1).
  - Else: peak stays 0.
- No update on cycles with sample_valid=0.
- clear=1 has priority over sample_valid in the same cycle: peak=0, hold=0, sample discarded. clear does not abort a running conversion.
- Refresh counter: free-running 0..REFRESH_CYCLES-1. tick=1 in the cycle it equals REFRESH_CYCLES-1, then it wraps to 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on tick, capture peak into a 15-bit shift register, zero the 20-bit BCD accumulator, iteration count=0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by one. After 15 SHIFT cycles go to DONE.
  - DONE: register the five nibbles onto digit4..digit0, pulse digits_valid=1, return to IDLE.
  - A tick arriving while not IDLE is ignored; this cannot occur given the REFRESH_CYCLES minimum.
- Latency: digits and digits_valid change on the 17th rising edge after the edge where tick was sampled. The converted value is the peak registered at that tick edge.
- busy=1 from the edge entering SHIFT through the DONE cycle.
- digit outputs hold their value between updates. Max value 32767 means digit4 is never >3.
- Reset asserted mid-conversion: FSM returns to IDLE immediately. Digits go to 0; no digits_valid pulse.

Test Plan:
- Reset then no samples, REFRESH_CYCLES=32 -> digits all 0, digits_valid pulse 17 clocks after each tick, peak=0.
- One sample -12345 -> peak=12345; next conversion gives digit4..0 = 1,2,3,4,5 with one digits_valid pulse.
- Sample -32768 -> peak=32767, digits 3,2,7,6,7. Sample +32767 gives the same.
- HOLD_SAMPLES=3, DECAY_SHIFT=4: sample 1600 then zeros -> peak holds at 1600 for 3 samples, then 1500, 1407, 1320. From peak 15, zeros decay by 1 per sample to 0, then stay 0.
- clear and sample_valid (sample=5000) asserted in the same cycle with peak=900 -> peak=0; clear during SHIFT -> conversion completes with the tick-time value (900).
- reset_n pulsed low during SHIFT -> busy=0, digits=0 immediately, no digits_valid. Next tick converts normally.
